// File: rtl/arm_pipelined_ext_pkg.sv
// Shared types for the pipelined immediate extension unit: mode encoding,
// pipeline entry layout and the 32-bit rotate helper.
package arm_pipelined_ext_pkg;

    localparam int ROT_BASE_WIDTH = 32;

    typedef enum logic [2:0] {
        EXT_ZERO8    = 3'b000,
        EXT_ZERO12   = 3'b001,
        EXT_ZERO24   = 3'b010,
        EXT_ROTATE   = 3'b011,
        EXT_BRANCH   = 3'b100,
        EXT_SIGN12   = 3'b101,
        EXT_HALFWORD = 3'b110,
        EXT_ILLEGAL  = 3'b111
    } ext_sel_t;

    typedef struct packed {
        logic                      valid;
        logic [ROT_BASE_WIDTH-1:0] data;
        logic                      carry;
        logic                      illegal;
    } ext_entry_t;

    // Rotate right by duplicating the word and shifting the 64-bit pair.
    function automatic logic [ROT_BASE_WIDTH-1:0] ror32(
        input logic [ROT_BASE_WIDTH-1:0] value,
        input logic [4:0]                amount
    );
        logic [2*ROT_BASE_WIDTH-1:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[ROT_BASE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/arm_pipelined_ext_decode.sv
// Combinational mode decode: forms the 32-bit result, shifter carry, illegal
// flag and whether the result must be sign-extended beyond bit 31.
module arm_pipelined_ext_decode
    import arm_pipelined_ext_pkg::*;
(
    input  logic [23:0]               imm,
    input  ext_sel_t                  sel,
    input  logic                      carry_in,
    output logic [ROT_BASE_WIDTH-1:0] data,
    output logic                      carry,
    output logic                      illegal,
    output logic                      sext
);

    logic [ROT_BASE_WIDTH-1:0] rot_result;

    assign rot_result = ror32({24'b0, imm[7:0]}, {imm[11:8], 1'b0});

    always_comb begin
        data    = '0;
        carry   = carry_in;
        illegal = 1'b0;
        sext    = 1'b0;
        case (sel)
            EXT_ZERO8:    data = {24'b0, imm[7:0]};
            EXT_ZERO12:   data = {20'b0, imm[11:0]};
            EXT_ZERO24:   data = {8'b0, imm[23:0]};
            EXT_ROTATE: begin
                data  = rot_result;
                // A zero rotate field leaves the C flag untouched.
                carry = (imm[11:8] == 4'd0) ? carry_in : rot_result[31];
            end
            EXT_BRANCH: begin
                data = {{6{imm[23]}}, imm[23:0], 2'b00};
                sext = 1'b1;
            end
            EXT_SIGN12: begin
                data = {{20{imm[11]}}, imm[11:0]};
                sext = 1'b1;
            end
            EXT_HALFWORD: data = {24'b0, imm[11:8], imm[3:0]};
            EXT_ILLEGAL: begin
                carry   = 1'b0;
                illegal = 1'b1;
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/arm_pipelined_immediate_unit.sv
// Immediate extension unit with a 1- or 2-stage register pipeline that follows
// the decode/execute registers through stall, flush and reset.
module arm_pipelined_immediate_unit
    import arm_pipelined_ext_pkg::*;
#(
    parameter int ImmediateBusWidth = 24,
    parameter int ExtendedBusWidth  = 32,
    parameter int Stages            = 1
) (
    input  logic                         i_CLK,
    input  logic                         i_NRESET,
    input  logic                         i_Valid,
    input  logic                         i_Stall,
    input  logic                         i_Flush,
    input  logic [ImmediateBusWidth-1:0] i_Immediate,
    input  logic [2:0]                   i_ExtensionSelect,
    input  logic                         i_CarryIn,
    output logic                         o_Valid,
    output logic [ExtendedBusWidth-1:0]  o_Extension,
    output logic                         o_ShifterCarry,
    output logic                         o_IllegalSelect
);

    logic [ROT_BASE_WIDTH-1:0] dec_data;
    logic                      dec_carry;
    logic                      dec_illegal;
    logic                      dec_sext;

    arm_pipelined_ext_decode u_decode (
        .imm      (i_Immediate[23:0]),
        .sel      (ext_sel_t'(i_ExtensionSelect)),
        .carry_in (i_CarryIn),
        .data     (dec_data),
        .carry    (dec_carry),
        .illegal  (dec_illegal),
        .sext     (dec_sext)
    );

    ext_entry_t entry_next;
    logic       upper_next;

    always_comb begin
        entry_next = '0;
        upper_next = 1'b0;
        if (i_Valid) begin
            entry_next.valid   = 1'b1;
            entry_next.data    = dec_data;
            entry_next.carry   = dec_carry;
            entry_next.illegal = dec_illegal;
            upper_next         = dec_sext & dec_data[ROT_BASE_WIDTH-1];
        end
    end

    // upper_reg carries the bit replicated above bit 31 of the stored result.
    ext_entry_t stage_reg [Stages];
    logic       upper_reg [Stages];
    logic       clear;

    assign clear = !i_NRESET || i_Flush;

    if (Stages == 2) begin : g_two_stage
        always_ff @(posedge i_CLK) begin
            if (clear) begin
                stage_reg[0] <= '0;
                upper_reg[0] <= 1'b0;
                stage_reg[1] <= '0;
                upper_reg[1] <= 1'b0;
            end else if (!i_Stall) begin
                stage_reg[0] <= entry_next;
                upper_reg[0] <= upper_next;
                stage_reg[1] <= stage_reg[0];
                upper_reg[1] <= upper_reg[0];
            end
        end
    end else begin : g_one_stage
        always_ff @(posedge i_CLK) begin
            if (clear) begin
                stage_reg[0] <= '0;
                upper_reg[0] <= 1'b0;
            end else if (!i_Stall) begin
                stage_reg[0] <= entry_next;
                upper_reg[0] <= upper_next;
            end
        end
    end

    ext_entry_t last_entry;
    logic       last_upper;

    assign last_entry      = stage_reg[Stages-1];
    assign last_upper      = upper_reg[Stages-1];
    assign o_Valid         = last_entry.valid;
    assign o_ShifterCarry  = last_entry.carry;
    assign o_IllegalSelect = last_entry.illegal;

    if (ExtendedBusWidth > ROT_BASE_WIDTH) begin : g_wide
        assign o_Extension = {{(ExtendedBusWidth-ROT_BASE_WIDTH){last_upper}}, last_entry.data};
    end else begin : g_base
        assign o_Extension = last_entry.data;
    end

endmodule
